// File: rtl/hdc_frame_packer_pkg.sv
// Shared widths and FSM state encodings for the HDC frame packer.
package hdc_frame_packer_pkg;

  localparam int ADC_WORD_WIDTH  = 16;
  localparam int FRAME_WIDTH     = 1024;
  localparam int FRAME_WORDS     = FRAME_WIDTH / ADC_WORD_WIDTH;
  localparam int FRAME_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_FILL_OUT = 2'd1,
    S_STALL    = 2'd2
  } state_e;

endpackage

// File: rtl/hdc_frame_outreg.sv
// Frame-wide valid/ready holding register: load wins over accept, clear wins over both.
module hdc_frame_outreg #(
  parameter int W = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         accept_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d = 1'b1;
      dat_d = load_dat_i;
    end else if (accept_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/hdc_frame_packer.sv
// Packs ADC words into frames, double-buffered (assembly buffer + output register).
// HDC_FRAME_SEQ_EN: word 0 of each frame carries the frame sequence count instead of a sample.
module hdc_frame_packer
  import hdc_frame_packer_pkg::*;
#(
  parameter int WORD_W  = ADC_WORD_WIDTH,
  parameter int FRAME_W = FRAME_WIDTH,
  parameter int CNT_W   = FRAME_CNT_WIDTH
) (
  input  logic               Clk_CI,
  input  logic               Reset_RI,
  input  logic               Clear_SI,
  input  logic               SampleValid_SI,
  input  logic [WORD_W-1:0]  Sample_DI,
  output logic               SampleReady_SO,
  output logic               FrameValid_SO,
  output logic [FRAME_W-1:0] Frame_DO,
  input  logic               FrameReady_SI,
  output logic [CNT_W-1:0]   FrameCnt_DO
);

  localparam int N_WORDS = FRAME_W / WORD_W;
  localparam int PTR_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
`ifdef HDC_FRAME_SEQ_EN
  localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(0);
`endif
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_WORDS - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FRAME_W-1:0] asm_q, asm_d, load_dat;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               word_acc, frame_acc, last_word;
  logic               out_load, out_clear;

  // Ready depends on registered state only, so the HDC side never reaches the ADC side combinationally.
  assign SampleReady_SO = (state_q != S_STALL);
  assign word_acc       = SampleValid_SI & SampleReady_SO & ~Clear_SI;
  assign frame_acc      = FrameValid_SO & FrameReady_SI;
  assign last_word      = word_acc & (wr_ptr_q == LAST_PTR);

  always_comb begin
    asm_d = asm_q;
    if (word_acc) begin
      asm_d[int'(wr_ptr_q)*WORD_W +: WORD_W] = Sample_DI;
    end
    load_dat = asm_d;
`ifdef HDC_FRAME_SEQ_EN
    load_dat[CNT_W-1:0] = cnt_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    out_load  = 1'b0;
    out_clear = 1'b0;
    if (word_acc) begin
      wr_ptr_d = last_word ? FIRST_PTR : wr_ptr_q + PTR_W'(1);
    end
    if (Clear_SI) begin
      out_clear = 1'b1;
      wr_ptr_d  = FIRST_PTR;
      state_d   = S_FILL;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (last_word) begin
            out_load = 1'b1;
            state_d  = S_FILL_OUT;
          end
        end
        S_FILL_OUT: begin
          if (last_word) begin
            if (frame_acc) out_load = 1'b1;
            else           state_d  = S_STALL;
          end else if (frame_acc) begin
            state_d = S_FILL;
          end
        end
        S_STALL: begin
          if (frame_acc) begin
            out_load = 1'b1;
            state_d  = S_FILL_OUT;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
    if (out_load) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pointer resets to the first sample slot so sequence mode never overwrites word 0.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q  <= S_FILL;
      wr_ptr_q <= FIRST_PTR;
      asm_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign FrameCnt_DO = cnt_q;

  hdc_frame_outreg #(
    .W (FRAME_W)
  ) u_outreg (
    .clk_i      (Clk_CI),
    .rst_i      (Reset_RI),
    .clear_i    (out_clear),
    .load_i     (out_load),
    .load_dat_i (load_dat),
    .accept_i   (frame_acc),
    .vld_o      (FrameValid_SO),
    .dat_o      (Frame_DO)
  );

endmodule

// File: tb/tb_hdc_frame_packer.sv
// Bench for hdc_frame_packer: scenario table, directed corner sequences and a random run against a queue model.
`timescale 1ns/1ps
module tb_hdc_frame_packer;

  localparam int WW = 16;
  localparam int FW = 1024;
  localparam int CW = 4;
  localparam int NW = FW / WW;
`ifdef HDC_FRAME_SEQ_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int NS = NW - OFF;

  logic          clk = 1'b0;
  logic          rst, clr, sv, fr;
  logic [WW-1:0] smp;
  logic          srdy, fvld;
  logic [FW-1:0] frame;
  logic [CW-1:0] fcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hdc_frame_packer #(
    .WORD_W  (WW),
    .FRAME_W (FW),
    .CNT_W   (CW)
  ) dut (
    .Clk_CI         (clk),
    .Reset_RI       (rst),
    .Clear_SI       (clr),
    .SampleValid_SI (sv),
    .Sample_DI      (smp),
    .SampleReady_SO (srdy),
    .FrameValid_SO  (fvld),
    .Frame_DO       (frame),
    .FrameReady_SI  (fr),
    .FrameCnt_DO    (fcnt)
  );

  // Reference: a queue of collected samples; a full queue moves to the output slot when it is free.
  logic [WW-1:0] m_asm[$];
  logic          m_vld;
  logic [FW-1:0] m_frame;
  logic [CW-1:0] m_cnt;

  function automatic logic [FW-1:0] mk_frame(input int base, input logic [CW-1:0] seq);
    logic [FW-1:0] f;
    f = '0;
    if (OFF != 0) f[CW-1:0] = seq;
    for (int i = 0; i < NS; i++) f[(i+OFF)*WW +: WW] = WW'(base + i);
    return f;
  endfunction

  function automatic logic [FW-1:0] pack_model();
    logic [FW-1:0] f;
    f = '0;
    if (OFF != 0) f[CW-1:0] = m_cnt;
    for (int i = 0; i < NS; i++) f[(i+OFF)*WW +: WW] = m_asm[i];
    return f;
  endfunction

  task automatic model_reset();
    m_asm.delete();
    m_vld   = 1'b0;
    m_frame = '0;
    m_cnt   = '0;
  endtask

  task automatic model_step();
    logic rdy, facc, wacc;
    rdy  = (m_asm.size() < NS);
    facc = m_vld & fr;
    wacc = sv & rdy & ~clr;
    if (clr) begin
      m_asm.delete();
      m_vld = 1'b0;
    end else begin
      if (wacc) m_asm.push_back(smp);
      if (m_asm.size() == NS && (!m_vld || facc)) begin
        m_frame = pack_model();
        m_vld   = 1'b1;
        m_cnt   = m_cnt + 1'b1;
        m_asm.delete();
      end else if (facc) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int idx;
    total++;
    if (act !== exp) begin
      bad++;
      idx = -1;
      for (int w = 0; w < NW; w++)
        if (idx < 0 && act[w*WW +: WW] !== exp[w*WW +: WW]) idx = w;
      $display("FAIL %s: word %0d got %h want %h", nm, idx, act[idx*WW +: WW], exp[idx*WW +: WW]);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_ready"}, 64'(srdy), 64'(m_asm.size() < NS));
    chk({nm, "_fvld"},  64'(fvld), 64'(m_vld));
    chk({nm, "_cnt"},   64'(fcnt), 64'(m_cnt));
    if (m_vld) chk_frame({nm, "_frame"}, frame, m_frame);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; sv = 1'b0; fr = 1'b0; smp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic feed(input int n, input logic frv, input int base);
    for (int i = 0; i < n; i++) begin
      sv  = 1'b1;
      smp = WW'(base + i);
      fr  = frv;
      tick();
    end
    sv = 1'b0;
    fr = 1'b0;
  endtask

  typedef struct {
    int   n;
    logic frv;
    logic e_vld;
    logic e_rdy;
    int   e_cnt;
  } vec_t;

  vec_t vt[7];
  int   frpct;

  initial begin
    vt[0] = '{NS-1,   1'b1, 1'b0, 1'b1, 0};
    vt[1] = '{NS,     1'b0, 1'b1, 1'b1, 1};
    vt[2] = '{2*NS-1, 1'b0, 1'b1, 1'b1, 1};
    vt[3] = '{2*NS,   1'b0, 1'b1, 1'b0, 1};
    vt[4] = '{2*NS+3, 1'b0, 1'b1, 1'b0, 1};
    vt[5] = '{2*NS,   1'b1, 1'b1, 1'b1, 2};
    vt[6] = '{3*NS,   1'b1, 1'b1, 1'b1, 3};

    // Reset state
    do_reset();
    chk("rst_ready", 64'(srdy), 64'd1);
    chk("rst_fvld",  64'(fvld), 64'd0);
    chk("rst_cnt",   64'(fcnt), 64'd0);
    chk_frame("rst_frame", frame, '0);

    // Scenario table: offer n back-to-back words with a fixed FrameReady level
    for (int r = 0; r < 7; r++) begin
      do_reset();
      feed(vt[r].n, vt[r].frv, 16'h100 * r);
      chk($sformatf("vec%0d_fvld", r),  64'(fvld), 64'(vt[r].e_vld));
      chk($sformatf("vec%0d_ready", r), 64'(srdy), 64'(vt[r].e_rdy));
      chk($sformatf("vec%0d_cnt", r),   64'(fcnt), 64'(vt[r].e_cnt));
      chk_model($sformatf("vec%0d", r));
    end

    // Ramp 0..N-1, frame valid right after the last word
    do_reset();
    feed(NS, 1'b1, 0);
    chk("ramp_fvld", 64'(fvld), 64'd1);
    chk("ramp_word0", 64'(frame[WW-1:0]), 64'd0);
    chk("ramp_wordlast", 64'(frame[FW-1 -: WW]), 64'(NS - 1));
    chk("ramp_cnt", 64'(fcnt), 64'd1);

    // Stall: output held stable, then one accept pulse releases frame 2
    do_reset();
    feed(2*NS, 1'b0, 0);
    chk("stall_ready", 64'(srdy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      sv = 1'b1; smp = 16'hFFFF;
      tick();
      chk("stall_hold_vld", 64'(fvld), 64'd1);
      chk_frame("stall_hold_frame", frame, mk_frame(0, 0));
    end
    sv = 1'b0; fr = 1'b1;
    tick();
    fr = 1'b0;
    chk("stall_rel_vld", 64'(fvld), 64'd1);
    chk("stall_rel_ready", 64'(srdy), 64'd1);
    chk("stall_rel_cnt", 64'(fcnt), 64'd2);
    chk_frame("stall_rel_frame", frame, mk_frame(NS, 1));

    // Clear mid-frame discards the partial frame
    do_reset();
    feed(10, 1'b1, 16'h5000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    feed(NS, 1'b1, 16'hA000);
    chk("clr_fvld", 64'(fvld), 64'd1);
    chk("clr_word", 64'(frame[OFF*WW +: WW]), 64'hA000);
    chk_frame("clr_frame", frame, mk_frame(16'hA000, 0));

    // Clear beats frame accept and word accept in the same cycle
    do_reset();
    feed(NS, 1'b0, 0);
    clr = 1'b1; fr = 1'b1; sv = 1'b1; smp = 16'hDEAD;
    tick();
    clr = 1'b0; fr = 1'b0; sv = 1'b0;
    chk("clr3_fvld", 64'(fvld), 64'd0);
    chk("clr3_ready", 64'(srdy), 64'd1);
    chk("clr3_cnt", 64'(fcnt), 64'd1);
    feed(NS-1, 1'b1, 16'hB000);
    chk("clr3_short_fvld", 64'(fvld), 64'd0);
    feed(1, 1'b1, 16'hB000 + NS - 1);
    chk("clr3_full_fvld", 64'(fvld), 64'd1);
    chk_frame("clr3_frame", frame, mk_frame(16'hB000, 1));

    // Counter wrap: 2^CW + 1 frames leave the count at 1
    do_reset();
    feed(((1 << CW) + 1) * NS, 1'b1, 0);
    chk("wrap_cnt", 64'(fcnt), 64'd1);
    chk("wrap_word0", 64'(frame[WW-1:0]), (OFF != 0) ? 64'd0 : 64'((16'((1 << CW) * NS))));
    chk_model("wrap");

    // Asynchronous reset mid-frame with a pending frame
    do_reset();
    feed(NS + 20, 1'b0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst1_ready", 64'(srdy), 64'd1);
    chk("arst1_fvld", 64'(fvld), 64'd0);
    chk("arst1_cnt", 64'(fcnt), 64'd0);
    chk_frame("arst1_frame", frame, '0);
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-stall
    do_reset();
    feed(2*NS, 1'b0, 0);
    chk("arst2_pre_ready", 64'(srdy), 64'd0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst2_ready", 64'(srdy), 64'd1);
    chk("arst2_fvld", 64'(fvld), 64'd0);
    chk("arst2_cnt", 64'(fcnt), 64'd0);
    chk_frame("arst2_frame", frame, '0);
    rst = 1'b0;
    tick();
    chk_model("arst2_after");

    // Random traffic against the queue model
    do_reset();
    frpct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) begin
        case ($urandom_range(0, 3))
          0:       frpct = 2;
          1:       frpct = 50;
          2:       frpct = 97;
          default: frpct = 20;
        endcase
      end
      clr = ($urandom_range(0, 299) == 0);
      sv  = ($urandom_range(0, 9) < 8);
      fr  = ($urandom_range(0, 99) < frpct);
      smp = WW'($urandom);
      tick();
      chk_model("rand");
    end
    clr = 1'b0; sv = 1'b0; fr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
